// File: rtl/wq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wq_pkg
// Brief    : Shared types for the window_queue sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
package wq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } wq_state_t;

endpackage
`default_nettype wire

// File: rtl/dp_ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_sync
// Brief    : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_sync #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1536,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/window_queue.sv
`default_nettype none
// ============================================================================
// Module   : window_queue
// Brief    : Circular sample queue; each write past WINDOW streams the window.
// Revision : 1.0 - initial release
// ============================================================================
module window_queue
    import wq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1536,
    parameter int WINDOW = 1021,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [DATA_W-1:0] new_smpl,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              seq_first,
    output logic              seq_last,
    output logic              sequencing,
    output logic              full,
    output logic              overrun
);

    localparam logic [AW-1:0] c_ONE    = AW'(1);
    localparam logic [AW-1:0] c_LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_WIN    = AW'(WINDOW);
    localparam logic [AW-1:0] c_WIN_M1 = AW'(WINDOW - 1);

    wq_state_t         r_state, w_state_nxt;
    logic [AW-1:0]     r_wr_ptr, r_old_ptr, r_rd_ptr, r_cnt, r_rd_cnt;
    logic [AW-1:0]     w_old_nxt, w_cnt_nxt;
    logic              r_full, r_ovr, r_vld, r_first, r_last;
    logic              r_pend_vld;
    logic [DATA_W-1:0] r_pend_data, w_wdata;
    logic              w_do_write, w_full_nxt, w_drop;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_ONE;
    endfunction

    always_comb begin
        w_do_write  = (r_state == IDLE) && (wrt_smpl || r_pend_vld);
        w_wdata     = r_pend_vld ? r_pend_data : new_smpl;
        w_old_nxt   = r_full ? f_ptr_inc(r_old_ptr) : r_old_ptr;
        w_cnt_nxt   = r_full ? r_cnt : r_cnt + c_ONE;
        w_full_nxt  = (w_cnt_nxt == c_WIN);
        w_drop      = (r_state == SEQ) && wrt_smpl && r_pend_vld;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_do_write && w_full_nxt) w_state_nxt = SEQ;
            SEQ:     if (r_rd_cnt == c_WIN_M1)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_old_ptr   <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_cnt    <= '0;
            r_full      <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_ovr       <= 1'b0;
            r_vld       <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr  <= f_ptr_inc(r_wr_ptr);
                r_old_ptr <= w_old_nxt;
                r_cnt     <= w_cnt_nxt;
                r_full    <= w_full_nxt;
            end

            if (r_state == IDLE) begin
                if (w_do_write && w_full_nxt) begin
                    r_rd_ptr <= w_old_nxt;
                    r_rd_cnt <= '0;
                end
            end else begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                r_rd_cnt <= r_rd_cnt + c_ONE;
            end

            // Slot drains in IDLE; a same-cycle strobe refills it behind the drained sample.
            if (r_state == IDLE) begin
                if (r_pend_vld) begin
                    r_pend_vld <= wrt_smpl;
                    if (wrt_smpl) r_pend_data <= new_smpl;
                end
            end else if (wrt_smpl && !r_pend_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= new_smpl;
            end

            if (w_drop)       r_ovr <= 1'b1;
            else if (clr_ovr) r_ovr <= 1'b0;

            r_vld   <= (r_state == SEQ);
            r_first <= (r_state == SEQ) && (r_rd_cnt == '0);
            r_last  <= (r_state == SEQ) && (r_rd_cnt == c_WIN_M1);
        end
    end

    dp_ram_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_do_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (smpl_out)
    );

    assign smpl_vld   = r_vld;
    assign seq_first  = r_first;
    assign seq_last   = r_last;
    assign sequencing = (r_state == SEQ) | r_vld;
    assign full       = r_full;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_window_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_queue
// Brief    : Scoreboard bench for window_queue (DEPTH=8, WINDOW=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_queue;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int WINDOW = 5;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              f;
        logic              l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wrt_smpl = 1'b0;
    logic [DATA_W-1:0] new_smpl = '0;
    logic              clr_ovr = 1'b0;
    logic [DATA_W-1:0] smpl_out;
    logic              smpl_vld, seq_first, seq_last, sequencing, full, overrun;

    exp_t sb[$];
    exp_t m_e;
    int   n_pass = 0;
    int   n_tot  = 0;

    window_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .new_smpl   (new_smpl),
        .clr_ovr    (clr_ovr),
        .smpl_out   (smpl_out),
        .smpl_vld   (smpl_vld),
        .seq_first  (seq_first),
        .seq_last   (seq_last),
        .sequencing (sequencing),
        .full       (full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push5(input int a, input int b, input int c, input int d, input int e);
        sb.push_back('{d: DATA_W'(a), f: 1'b1, l: 1'b0});
        sb.push_back('{d: DATA_W'(b), f: 1'b0, l: 1'b0});
        sb.push_back('{d: DATA_W'(c), f: 1'b0, l: 1'b0});
        sb.push_back('{d: DATA_W'(d), f: 1'b0, l: 1'b0});
        sb.push_back('{d: DATA_W'(e), f: 1'b0, l: 1'b1});
    endtask

    task automatic push_run(input int s);
        push5(s, s + 1, s + 2, s + 3, s + 4);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_cycle(input int v);
        wrt_smpl = 1'b1;
        new_smpl = DATA_W'(v);
        @(posedge clk);
        #1;
        wrt_smpl = 1'b0;
    endtask

    // Monitor: every valid output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && smpl_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_vld", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("smpl_out", 32'(smpl_out), 32'(m_e.d));
                chk("seq_first", 32'(seq_first), 32'(m_e.f));
                chk("seq_last", 32'(seq_last), 32'(m_e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("rst_smpl_vld", 32'(smpl_vld), 0);
        chk("rst_seq_first", 32'(seq_first), 0);
        chk("rst_seq_last", 32'(seq_last), 0);
        chk("rst_sequencing", 32'(sequencing), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Fill: four writes hold, fifth triggers the first burst
        for (int v = 1; v <= 4; v++) write_cycle(v);
        chk("fill_full", 32'(full), 0);
        idle(2);
        chk("fill_no_burst", 32'(sequencing), 0);
        push_run(1);
        write_cycle(5);
        chk("t1_vld", 32'(smpl_vld), 0);
        chk("t1_full", 32'(full), 1);
        chk("t1_sequencing", 32'(sequencing), 1);
        idle(1);
        chk("t2_vld", 32'(smpl_vld), 1);
        idle(4);
        chk("t6_vld", 32'(smpl_vld), 1);
        idle(1);
        chk("t7_vld", 32'(smpl_vld), 0);
        chk("t7_sequencing", 32'(sequencing), 0);

        // Sliding window with write-pointer wrap
        for (int v = 6; v <= 8; v++) begin
            push_run(v - 4);
            write_cycle(v);
            idle(7);
        end
        chk("slide_overrun", 32'(overrun), 0);

        // Mid-burst pending write, then a drop
        push_run(5);
        write_cycle(9);
        idle(1);
        push_run(6);
        write_cycle(10);
        for (int i = 0; i < 16; i++) begin
            chk("seq_gapless", 32'(sequencing), 1);
            if (i == 5) begin
                push_run(7);
                wrt_smpl = 1'b1;
                new_smpl = 16'd11;
            end else if (i == 6) begin
                wrt_smpl = 1'b1;
                new_smpl = 16'd12;
            end
            @(posedge clk);
            #1;
            wrt_smpl = 1'b0;
        end
        chk("seq_end", 32'(sequencing), 0);
        chk("ovr_set", 32'(overrun), 1);

        // Overrun clear, and set-over-clear priority
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        push5(8, 9, 10, 11, 13);
        write_cycle(13);
        push5(9, 10, 11, 13, 14);
        write_cycle(14);
        wrt_smpl = 1'b1;
        new_smpl = 16'd15;
        clr_ovr  = 1'b1;
        idle(1);
        wrt_smpl = 1'b0;
        clr_ovr  = 1'b0;
        chk("ovr_set_prio", 32'(overrun), 1);
        idle(12);
        chk("ovr_sticky", 32'(overrun), 1);
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        chk("ovr_clr2", 32'(overrun), 0);

        // Reset at the third beat of a burst
        push5(10, 11, 13, 14, 16);
        write_cycle(16);
        idle(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_smpl_vld", 32'(smpl_vld), 0);
        chk("arst_sequencing", 32'(sequencing), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_beats_left", 32'(sb.size()), 3);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int v = 21; v <= 24; v++) write_cycle(v);
        chk("refill_full", 32'(full), 0);
        idle(3);
        chk("refill_no_burst", 32'(sequencing), 0);
        push_run(21);
        write_cycle(25);
        chk("refill_full5", 32'(full), 1);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        idle(3);
        chk("drain", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
